// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and constants.
package fetch_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetchState_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer parking a fetched {instr, pcPlus4} while the stage is held.
// clear beats load beats consume.
module fetch_skid_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              load,
    input  logic              clear,
    input  logic              consume,
    input  logic [DATA_W-1:0] loadInstr,
    input  logic [ADDR_W-1:0] loadPcPlus4,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic              valid
);

    // entry register with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetN || clear) begin
            instr   <= '0;
            pcPlus4 <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= loadInstr;
            pcPlus4 <= loadPcPlus4;
            valid   <= 1'b1;
        end else if (consume) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: PC, IF/ID register, imem handshake, hazard hold and
// branch redirect. Optional stall counter behind FETCH_STALL_COUNT_EN.
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              pcWrite,
    input  logic              ifWrite,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemReady,
    input  logic [DATA_W-1:0] imemRdata,
    output logic [DATA_W-1:0] ifIdInstr,
    output logic [ADDR_W-1:0] ifIdPcPlus4,
    output logic              ifIdValid,
    output logic              fetchBusy
`ifdef FETCH_STALL_COUNT_EN
    ,output logic [31:0]      stallCount
`endif
);

    fetchState_t       state, nextState;
    logic [ADDR_W-1:0] pc, pcNext, pcPlus4;
    logic [ADDR_W-1:0] drainAddr, drainNext;
    logic              hold, reqActive;
    logic              ifLoad, ifValidNext;
    logic [DATA_W-1:0] ifInstrNext;
    logic [ADDR_W-1:0] ifPcNext;
    logic              skidLoad, skidClear, skidConsume, skidValid;
    logic [DATA_W-1:0] skidInstr;
    logic [ADDR_W-1:0] skidPcPlus4;

    assign hold      = !pcWrite || !ifWrite;
    assign pcPlus4   = pc + ADDR_W'(PC_INC);
    assign reqActive = (state != S_HOLD);
    // drain keeps the address of the abandoned request on the bus until it completes
    assign imemReq   = resetN && reqActive;
    assign imemAddr  = (state == S_DRAIN) ? drainAddr : pc;
    assign fetchBusy = imemReq && !imemReady;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uSkid (
        .clk         (clk),
        .resetN      (resetN),
        .load        (skidLoad),
        .clear       (skidClear),
        .consume     (skidConsume),
        .loadInstr   (imemRdata),
        .loadPcPlus4 (pcPlus4),
        .instr       (skidInstr),
        .pcPlus4     (skidPcPlus4),
        .valid       (skidValid)
    );

    // next-state, PC and IF/ID update; priority flush > hold > normal
    always_comb begin
        nextState   = state;
        pcNext      = pc;
        drainNext   = drainAddr;
        ifLoad      = 1'b0;
        ifInstrNext = DATA_W'(NOP);
        ifPcNext    = pcPlus4;
        ifValidNext = 1'b0;
        skidLoad    = 1'b0;
        skidClear   = 1'b0;
        skidConsume = 1'b0;
        if (flush) begin
            pcNext    = branchTarget;
            ifLoad    = 1'b1;
            skidClear = 1'b1;
            if (reqActive && !imemReady) begin
                nextState = S_DRAIN;
                drainNext = imemAddr;
            end else begin
                nextState = S_REQ;
            end
        end else begin
            case (state)
                S_REQ, S_WAIT: begin
                    if (hold) begin
                        if (imemReady) begin
                            skidLoad  = 1'b1;
                            nextState = S_HOLD;
                        end else begin
                            nextState = S_WAIT;
                        end
                    end else if (imemReady) begin
                        ifLoad      = 1'b1;
                        ifInstrNext = imemRdata;
                        ifValidNext = 1'b1;
                        pcNext      = pcPlus4;
                        nextState   = S_REQ;
                    end else begin
                        ifLoad    = 1'b1;
                        nextState = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        ifLoad      = 1'b1;
                        ifInstrNext = skidInstr;
                        ifPcNext    = skidPcPlus4;
                        ifValidNext = skidValid;
                        pcNext      = pcPlus4;
                        skidConsume = 1'b1;
                        nextState   = S_REQ;
                    end
                end
                S_DRAIN: begin
                    // stale data is dropped; hold only suppresses the bubble
                    ifLoad = !hold;
                    if (imemReady) nextState = S_REQ;
                end
                default: nextState = S_REQ;
            endcase
        end
    end

    // state, PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= S_REQ;
            pc          <= ADDR_W'(RESET_PC);
            drainAddr   <= '0;
            ifIdInstr   <= '0;
            ifIdPcPlus4 <= '0;
            ifIdValid   <= 1'b0;
        end else begin
            state     <= nextState;
            pc        <= pcNext;
            drainAddr <= drainNext;
            if (ifLoad) begin
                ifIdInstr   <= ifInstrNext;
                ifIdPcPlus4 <= ifPcNext;
                ifIdValid   <= ifValidNext;
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic stallEvent;
    assign stallEvent = hold || (ifLoad && !ifValidNext);

    // saturating count of hold cycles and inserted bubbles
    always_ff @(posedge clk) begin
        if (!resetN)
            stallCount <= '0;
        else if (stallEvent && stallCount != 32'hFFFF_FFFF)
            stallCount <= stallCount + 32'd1;
    end
`else
    // stall counter not built
`endif

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Instruction-fetch stage controller for the 5-stage pipeline: owns the PC register and the IF/ID pipeline register, and is the consumer of the load-use hazard signals `pcWrite`/`ifWrite` and of the EX-stage branch flush. It drives a variable-latency instruction-memory request/ready handshake. It inserts bubbles on memory wait states, holds on hazards via a one-entry skid buffer, and redirects on taken branches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `ADDR_W`, default 32: PC/address width.
- `DATA_W`, default 32: instruction width.

- `clk` input 1: sole clock, rising edge.
- `resetN` input 1: synchronous, active-low reset.
- `pcWrite` input 1: 0 = hold PC (hazard stall).
- `ifWrite` input 1: 0 = hold IF/ID (hazard stall).
- `flush` input 1: taken branch/jump resolved in EX.
- `branchTarget` input ADDR_W: redirect address, valid with `flush`.
- `imemReq` output 1: fetch request.
- `imemAddr` output ADDR_W: fetch address, stable while `imemReq`=1 and `imemReady`=0.
- `imemReady` input 1: `imemRdata` valid; completes the request this cycle.
- `imemRdata` input DATA_W: fetched instruction.
- `ifIdInstr` output DATA_W: IF/ID instruction.
- `ifIdPcPlus4` output ADDR_W: IF/ID PC+4.
- `ifIdValid` output 1: IF/ID holds a real instruction.
- `fetchBusy` output 1: a request is outstanding and has not completed this cycle.

## Operation
- `hold` = !pcWrite || !ifWrite. Priority: reset > flush > hold > normal.
- FSM states:
  - S_REQ: `imemReq`=1, `imemAddr`=pc.
  - S_WAIT: request outstanding.
  - S_HOLD: instruction parked in the skid buffer.
  - S_DRAIN: discard the stale response after a flush.
- S_REQ/S_WAIT, `imemReady`=1, no hold, no flush:
  - IF/ID <= {imemRdata, pc+4, valid=1}; pc <= pc+4; next state S_REQ.
- S_REQ/S_WAIT, `imemReady`=0, no hold:
  - IF/ID <= bubble {32'h0, pc+4, valid=0}; next state S_WAIT.
- Hold in any state: IF/ID and PC retain their values.
  - If `imemReady`=1, store {imemRdata, pc+4} in the skid buffer and go to S_HOLD.
  - In S_HOLD, `imemReq`=0.
  - On the first cycle with hold=0: IF/ID <= buffer (valid=1), pc <= pc+4, next state S_REQ.
- Flush in any state:
  - pc <= branchTarget; IF/ID <= bubble (valid=0); skid buffer invalidated.
  - If a request is outstanding and `imemReady`=0 this cycle, next state S_DRAIN. Otherwise next state S_REQ.
- S_DRAIN: `imemReq`=1, `imemAddr`=old address. When `imemReady`=1, discard the data and go to S_REQ. IF/ID inserts bubbles meanwhile.
- Flush during S_DRAIN updates pc again; the state remains S_DRAIN.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.

## Timing
- Reset values:
  - pc = RESET_PC; state = S_REQ.
  - `imemReq`=0 while `resetN`=0.
  - IF/ID = {0, 0, valid=0}; `fetchBusy`=0.
- First request is asserted in the first cycle after `resetN` rises.
- `imemReq`/`imemAddr` are combinational from state and pc. `imemReady` is sampled on the same edge as IF/ID capture.
- With zero-wait memory (`imemReady`=1 in the same cycle), throughput is 1 instruction/cycle and fetch-to-IF/ID latency is 1 cycle.
- Each memory wait cycle inserts exactly one bubble. Hazard hold adds no bubble and loses no instruction.
- Branch penalty: IF/ID is a bubble in the cycle after `flush`; the target is requested in that same cycle unless draining.
- `fetchBusy` = `imemReq` && !`imemReady`.

## Configuration
- `FETCH_STALL_COUNT_EN`: when defined, adds output `stallCount` (32 bits). It counts cycles with hold=1 or a bubble inserted, saturates at 32'hFFFF_FFFF, and is cleared by reset. When undefined, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package: FSM state encoding (S_REQ=0, S_WAIT=1, S_HOLD=2, S_DRAIN=3), NOP constant 32'h0000_0000, PC increment constant 4.
- One sub-module, `fetch_skid_buf`: a one-entry {instr, pcPlus4, valid} register with load/clear/consume controls.

## Test plan
- Reset, RESET_PC=32'h100, zero-wait memory -> `imemAddr` sequence 100, 104, 108 on consecutive cycles; IF/ID valid from cycle 2 with `ifIdPcPlus4`=104.
- `imemReady` low for 2 cycles at addr 0x104 -> two bubbles (`ifIdValid`=0, instr 0); `imemAddr` stays 0x104; then the instruction is captured with pcPlus4=0x108.
- pcWrite=ifWrite=0 for 1 cycle while data 0xDEADBEEF returns -> IF/ID unchanged; next cycle IF/ID=0xDEADBEEF, valid=1; no address skipped.
- flush with target 0x200 while in S_WAIT -> S_DRAIN; the stale return is dropped; the next request goes to 0x200; IF/ID shows bubbles until 0x200 data arrives.
- flush and hold asserted together -> flush wins: pc=0x200, IF/ID bubble, skid buffer cleared.
- pc=32'hFFFF_FFFC, zero-wait memory -> next `imemAddr`=0x0; `ifIdPcPlus4`=0x0.
